// File: rtl/rot_pkg.sv
// Shared types and constants for the fixed-point point rotation engine.
// Saturation behaviour of the datapath is selected by the ROT_SATURATE_EN macro.
package rot_pkg;

  localparam int FRAC_BITS  = 14;
  localparam int ROUND_BIAS = 1 << (FRAC_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    AXIS_Z  = 2'd0,
    AXIS_X  = 2'd1,
    AXIS_Y  = 2'd2,
    AXIS_ID = 2'd3
  } axis_e;

endpackage

// File: rtl/rot_if.sv
// Request/result bundle between the point-streaming controller (master)
// and the rotation engine (slave).
interface rot_if #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16
);
  logic                     start;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_in;
  logic signed [DATA_W-1:0] z_in;
  logic signed [COEF_W-1:0] cos_theta;
  logic signed [COEF_W-1:0] sin_theta;
  logic [1:0]               axis;
  logic signed [DATA_W-1:0] x_out;
  logic signed [DATA_W-1:0] y_out;
  logic signed [DATA_W-1:0] z_out;
  logic                     out_ready;
  logic                     busy;
  logic                     ovf;

  modport master (
    output start, x_in, y_in, z_in, cos_theta, sin_theta, axis,
    input  x_out, y_out, z_out, out_ready, busy, ovf
  );

  modport slave (
    input  start, x_in, y_in, z_in, cos_theta, sin_theta, axis,
    output x_out, y_out, z_out, out_ready, busy, ovf
  );
endinterface

// File: rtl/rot_mac.sv
// Shared signed multiplier with two accumulators and a round/limit stage.
// ROT_SATURATE_EN defined: clamp out-of-range results and flag them; else wrap.
module rot_mac
  import rot_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic [1:0]               k,
  input  logic signed [COEF_W-1:0] cos_c,
  input  logic signed [COEF_W-1:0] sin_c,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  output logic signed [DATA_W-1:0] res_a,
  output logic signed [DATA_W-1:0] res_b,
  output logic                     ovf
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 1;

  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] data_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0]  acc_b_q, acc_b_d;
  logic [DATA_W:0]          fit_a;
  logic [DATA_W:0]          fit_b;

  // Returns {limited, value}: round half up, drop fraction bits, then fit to DATA_W.
  function automatic logic [DATA_W:0] fit(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] biased;
    biased = acc + ACC_W'(ROUND_BIAS);
`ifdef ROT_SATURATE_EN
    begin
      logic signed [ACC_W-1:0] shifted;
      shifted = biased >>> FRAC_BITS;
      if (&shifted[ACC_W-1:DATA_W-1] || ~|shifted[ACC_W-1:DATA_W-1])
        fit = {1'b0, shifted[DATA_W-1:0]};
      else if (shifted[ACC_W-1])
        fit = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      else
        fit = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    fit = {1'b0, DATA_W'(biased >>> FRAC_BITS)};
`endif
  endfunction

  // k selects the term: 0 c*a, 1 s*b, 2 s*a, 3 c*b.
  always_comb begin
    coef_ext = (k == 2'd0 || k == 2'd3) ? {{DATA_W{cos_c[COEF_W-1]}}, cos_c}
                                         : {{DATA_W{sin_c[COEF_W-1]}}, sin_c};
    data_ext = (k == 2'd0 || k == 2'd2) ? {{COEF_W{op_a[DATA_W-1]}}, op_a}
                                         : {{COEF_W{op_b[DATA_W-1]}}, op_b};
    prod     = coef_ext * data_ext;
    prod_ext = {prod[PROD_W-1], prod};
  end

  always_comb begin
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    if (clr) begin
      acc_a_d = '0;
      acc_b_d = '0;
    end else if (en) begin
      case (k)
        2'd0:    acc_a_d = acc_a_q + prod_ext;
        2'd1:    acc_a_d = acc_a_q - prod_ext;
        2'd2:    acc_b_d = acc_b_q + prod_ext;
        default: acc_b_d = acc_b_q + prod_ext;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
    end else begin
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
    end
  end

  always_comb begin
    fit_a = fit(acc_a_q);
    fit_b = fit(acc_b_q);
    res_a = fit_a[DATA_W-1:0];
    res_b = fit_b[DATA_W-1:0];
    ovf   = fit_a[DATA_W] | fit_b[DATA_W];
  end

endmodule

// File: rtl/rot_engine.sv
// 3-D point rotation responder: latches a request, runs four shared-multiplier
// cycles, then presents the rotated point. ROT_SATURATE_EN selects clamping in rot_mac.
module rot_engine
  import rot_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16
) (
  input logic   clk,
  input logic   reset,
  rot_if.slave  bus
);

  state_e                   state_q, state_d;
  logic [1:0]               k_q, k_d;
  logic signed [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [COEF_W-1:0] cos_q, cos_d, sin_q, sin_d;
  axis_e                    axis_q, axis_d;
  logic signed [DATA_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic                     out_ready_q, out_ready_d;
  logic                     busy_q, busy_d;
  logic                     ovf_q, ovf_d;

  logic                     mac_clr, mac_en, mac_ovf;
  logic signed [DATA_W-1:0] op_a, op_b, res_a, res_b;

  rot_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .k     (k_q),
    .cos_c (cos_q),
    .sin_c (sin_q),
    .op_a  (op_a),
    .op_b  (op_b),
    .res_a (res_a),
    .res_b (res_b),
    .ovf   (mac_ovf)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      axis_q      <= AXIS_Z;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      axis_q      <= axis_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_out_q     <= z_out_d;
      out_ready_q <= out_ready_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MUL;
      MUL:     if (k_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand pair per axis; identity still feeds the MAC so latency stays uniform.
  always_comb begin
    case (axis_q)
      AXIS_X:  begin op_a = y_q; op_b = z_q; end
      AXIS_Y:  begin op_a = z_q; op_b = x_q; end
      default: begin op_a = x_q; op_b = y_q; end
    endcase
  end

  // NOTE: every output gets a default first; a path that skips an assignment would infer a latch.
  always_comb begin
    k_d         = k_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    axis_d      = axis_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    z_out_d     = z_out_q;
    out_ready_d = out_ready_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d         = bus.x_in;
          y_d         = bus.y_in;
          z_d         = bus.z_in;
          cos_d       = bus.cos_theta;
          sin_d       = bus.sin_theta;
          axis_d      = axis_e'(bus.axis);
          k_d         = '0;
          mac_clr     = 1'b1;
          busy_d      = 1'b1;
          out_ready_d = 1'b0;
        end
      end
      MUL: begin
        mac_en = 1'b1;
        k_d    = k_q + 2'd1;
      end
      DONE: begin
        case (axis_q)
          AXIS_Z:  begin x_out_d = res_a; y_out_d = res_b; z_out_d = z_q;   end
          AXIS_X:  begin x_out_d = x_q;   y_out_d = res_a; z_out_d = res_b; end
          AXIS_Y:  begin x_out_d = res_b; y_out_d = y_q;   z_out_d = res_a; end
          default: begin x_out_d = x_q;   y_out_d = y_q;   z_out_d = z_q;   end
        endcase
        ovf_d       = (axis_q != AXIS_ID) && mac_ovf;
        out_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;
  assign bus.z_out     = z_out_q;
  assign bus.out_ready = out_ready_q;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_rot_engine.sv
// Self-checking bench for rot_engine: a timeline model of request/result behaviour
// compared every cycle, plus directed literal checks. Honours ROT_SATURATE_EN.
module tb_rot_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rot_if #(.DATA_W(32), .COEF_W(16)) bus ();

  rot_engine #(.DATA_W(32), .COEF_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint mul(input logic signed [15:0] c, input logic signed [31:0] d);
    return longint'(c) * longint'(d);
  endfunction

  function automatic logic [32:0] fit(input longint acc);
    longint r;
    r = (acc + 64'sd8192) >>> 14;
`ifdef ROT_SATURATE_EN
    if (r > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
    return {1'b0, r[31:0]};
  endfunction

  logic [31:0]        m_x, m_y, m_z;
  logic               m_ready, m_busy, m_ovf;
  int                 m_cnt;
  logic signed [31:0] c_x, c_y, c_z;
  logic signed [15:0] c_c, c_s;
  logic [1:0]         c_ax;
  logic [32:0]        ra, rb;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_x = 0; m_y = 0; m_z = 0;
      m_ready = 0; m_busy = 0; m_ovf = 0; m_cnt = 0;
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        case (c_ax)
          2'd0: begin
            ra = fit(mul(c_c, c_x) - mul(c_s, c_y));
            rb = fit(mul(c_s, c_x) + mul(c_c, c_y));
            m_x = ra[31:0]; m_y = rb[31:0]; m_z = c_z; m_ovf = ra[32] | rb[32];
          end
          2'd1: begin
            ra = fit(mul(c_c, c_y) - mul(c_s, c_z));
            rb = fit(mul(c_s, c_y) + mul(c_c, c_z));
            m_x = c_x; m_y = ra[31:0]; m_z = rb[31:0]; m_ovf = ra[32] | rb[32];
          end
          2'd2: begin
            ra = fit(mul(c_c, c_z) - mul(c_s, c_x));
            rb = fit(mul(c_s, c_z) + mul(c_c, c_x));
            m_x = rb[31:0]; m_y = c_y; m_z = ra[31:0]; m_ovf = ra[32] | rb[32];
          end
          default: begin
            m_x = c_x; m_y = c_y; m_z = c_z; m_ovf = 1'b0;
          end
        endcase
        m_busy  = 0;
        m_ready = 1;
      end
    end else if (bus.start) begin
      c_x = bus.x_in; c_y = bus.y_in; c_z = bus.z_in;
      c_c = bus.cos_theta; c_s = bus.sin_theta; c_ax = bus.axis;
      m_cnt = 5; m_busy = 1; m_ready = 0;
    end
  end

  // Continuous comparison against the model.
  always @(negedge clk) begin
    check("x_out", bus.x_out, m_x);
    check("y_out", bus.y_out, m_y);
    check("z_out", bus.z_out, m_z);
    check("out_ready", 32'(bus.out_ready), 32'(m_ready));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("ovf", 32'(bus.ovf), 32'(m_ovf));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] x, y, z, input logic [15:0] c, s,
                       input logic [1:0] ax, input logic st);
    bus.x_in = x; bus.y_in = y; bus.z_in = z;
    bus.cos_theta = c; bus.sin_theta = s; bus.axis = ax; bus.start = st;
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    if (r[31:30] == 2'b00) return r;
    return {{14{r[17]}}, r[17:0]};
  endfunction

  task automatic drive_random(input logic st);
    drive(rnd_data(), rnd_data(), rnd_data(), 16'($urandom), 16'($urandom),
          2'($urandom_range(0, 3)), st);
  endtask

  task automatic run_req(input logic [31:0] x, y, z, input logic [15:0] c, s,
                         input logic [1:0] ax, input bit poke_busy);
    int lat;
    @(negedge clk);
    drive(x, y, z, c, s, ax, 1'b1);
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        check("ready_clear_on_accept", 32'(bus.out_ready), 32'd0);
      end
      if (poke_busy && i == 3) drive(32'h1234_5678, 32'h0BAD_0000, 32'h7777_0000, 16'h1000, 16'h2000, 2'd0, 1'b1);
      if (poke_busy && i == 4) bus.start = 1'b0;
      if (bus.out_ready) lat = i;
    end
    if (lat == 0) check("result_timeout", 32'd0, 32'd1);
    else          check("latency", 32'(lat), 32'd6);
  endtask

  logic [31:0] exp_sat;
  logic        exp_sat_ovf;
  int          rises[$];
  logic        prev_ready;
  logic        seen_ready;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    #3;
    check("reset_x_out", bus.x_out, 32'd0);
    check("reset_out_ready", 32'(bus.out_ready), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Identity rotation about Z.
    run_req(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 16'd16384, 16'd0, 2'd0, 1'b0);
    check("ident_x", bus.x_out, 32'h0001_0000);
    check("ident_y", bus.y_out, 32'h0002_0000);
    check("ident_z", bus.z_out, 32'h0003_0000);
    check("ident_ovf", 32'(bus.ovf), 32'd0);

    // 90 degrees about Z, X, Y.
    run_req(32'h0001_0000, 32'd0, 32'h0003_0000, 16'd0, 16'd16384, 2'd0, 1'b0);
    check("rotz_x", bus.x_out, 32'd0);
    check("rotz_y", bus.y_out, 32'h0001_0000);
    check("rotz_z", bus.z_out, 32'h0003_0000);
    run_req(32'h0005_0000, 32'h0001_0000, 32'd0, 16'd0, 16'd16384, 2'd1, 1'b0);
    check("rotx_x", bus.x_out, 32'h0005_0000);
    check("rotx_y", bus.y_out, 32'd0);
    check("rotx_z", bus.z_out, 32'h0001_0000);
    run_req(32'd0, 32'h0006_0000, 32'h0001_0000, 16'd0, 16'd16384, 2'd2, 1'b0);
    check("roty_x", bus.x_out, 32'h0001_0000);
    check("roty_y", bus.y_out, 32'h0006_0000);
    check("roty_z", bus.z_out, 32'd0);

    // Round half up.
    run_req(32'd3, 32'd0, 32'd0, 16'd8192, 16'd0, 2'd0, 1'b0);
    check("round_pos", bus.x_out, 32'd2);
    run_req(32'hFFFF_FFFD, 32'd0, 32'd0, 16'd8192, 16'd0, 2'd0, 1'b0);
    check("round_neg", bus.x_out, 32'hFFFF_FFFF);

    // Out-of-range result.
`ifdef ROT_SATURATE_EN
    exp_sat = 32'h7FFF_FFFF; exp_sat_ovf = 1'b1;
`else
    exp_sat = 32'hFFFF_FFFE; exp_sat_ovf = 1'b0;
`endif
    run_req(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 16'd16384, 16'd16384, 2'd0, 1'b0);
    check("sat_x", bus.x_out, 32'd0);
    check("sat_y", bus.y_out, exp_sat);
    check("sat_ovf", 32'(bus.ovf), 32'(exp_sat_ovf));

    // start while busy is ignored; result stays with the first request.
    run_req(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 16'd16384, 16'd0, 2'd3, 1'b1);
    check("busy_ignore_x", bus.x_out, 32'h0001_0000);
    check("busy_ignore_y", bus.y_out, 32'h0002_0000);
    check("busy_ignore_z", bus.z_out, 32'h0003_0000);
    repeat (4) @(negedge clk);
    check("ready_hold", 32'(bus.out_ready), 32'd1);

    // start held high: back-to-back requests every 6 cycles.
    @(negedge clk);
    prev_ready = bus.out_ready;
    drive_random(1'b1);
    for (int i = 0; i < 40 && rises.size() < 3; i++) begin
      @(negedge clk);
      if (bus.out_ready && !prev_ready) rises.push_back(i);
      prev_ready = bus.out_ready;
      drive_random(1'b1);
    end
    bus.start = 1'b0;
    if (rises.size() < 3) check("b2b_timeout", 32'd0, 32'd1);
    else begin
      check("b2b_gap1", 32'(rises[1] - rises[0]), 32'd6);
      check("b2b_gap2", 32'(rises[2] - rises[1]), 32'd6);
    end
    repeat (8) @(negedge clk);

    // Reset in the middle of a computation.
    run_req(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 16'd16384, 16'd0, 2'd0, 1'b0);
    @(negedge clk);
    drive(32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 16'd16384, 16'd0, 2'd0, 1'b1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_x", bus.x_out, 32'd0);
    check("rst_async_y", bus.y_out, 32'd0);
    check("rst_async_z", bus.z_out, 32'd0);
    check("rst_async_busy", 32'(bus.busy), 32'd0);
    check("rst_async_ready", 32'(bus.out_ready), 32'd0);
    check("rst_async_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_ready |= bus.out_ready;
    end
    check("no_ready_after_reset", 32'(seen_ready), 32'd0);

    // Randomised traffic, including start pulses during busy and DONE.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive_random($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
